sw_debounce8: RTL

//  Front end for the 8-bit switch vector that feeds the priority encoder / 7-seg display stage.
//  - Synchronises raw board switches into clk.
//  - Debounces each bit independently.
//  - Presents a clean stable vector to the encoder, plus one-cycle rise/fall pulses and an any-active flag.

---
 rtl/sw_pkg.sv | 20 ++
 rtl/sw_debounce8_debounce_bit.sv | 85 ++++++++
 rtl/sw_debounce8.sv | 79 +++++++
 3 files changed

// File: rtl/sw_pkg.sv
// ---------------------------------------------------------------------------
// sw_pkg
//   Shared constants for the switch front end (sw_debounce8 / debounce_bit).
//   SW_WIDTH          number of board switches feeding the encoder
//   DEBOUNCE_DEFAULT  hold time, in synchronised cycles, for silicon builds
//   DEBOUNCE_SIM      short hold time so simulations stay quick
// ---------------------------------------------------------------------------
package sw_pkg;

    localparam int SW_WIDTH         = 8;
    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int DEBOUNCE_SIM     = 4;

    // Counter width for a given hold time. The counter only ever holds
    // 0 .. cycles-1, so clog2(cycles) bits is exactly enough (cycles >= 2).
    function automatic int debounce_cnt_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage : sw_pkg

// File: rtl/sw_debounce8_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//   One switch lane: two-flop synchroniser followed by a saturating
//   agreement counter. A new level is accepted only after the synchronised
//   input has disagreed with the current stable level for DEBOUNCE_CYCLES
//   consecutive clocks; any return to the stable level restarts the count.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   raw_bit     in   asynchronous switch level
//   stable_bit  out  debounced level (registered)
//   rise_bit    out  one-cycle pulse, stable went 0->1 (registered)
//   fall_bit    out  one-cycle pulse, stable went 1->0 (registered)
//   accept_bit  out  combinational: stable_bit flips on the coming edge.
//                    Lets the top register its summary flags on the same
//                    edge as stable/rise/fall rather than one cycle late.
// ---------------------------------------------------------------------------
module debounce_bit
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_bit,
    output logic stable_bit,
    output logic rise_bit,
    output logic fall_bit,
    output logic accept_bit
);

    localparam int               CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    logic             stable_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             differ;
    logic             accept;

    // Only the second synchroniser stage is allowed to influence state.
    assign differ = s2_reg ^ stable_reg;
    assign accept = differ && (cnt_reg == CNT_MAX);

    // Counter returns to zero both on agreement and on acceptance, so it
    // never exceeds CNT_MAX and cannot wrap.
    always_comb begin
        cnt_next = '0;
        if (differ && !accept) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            s1_reg   <= raw_bit;
            s2_reg   <= s1_reg;
            cnt_reg  <= cnt_next;
            // Pulses are re-evaluated every edge so they last one cycle.
            rise_reg <= accept &&  s2_reg;
            fall_reg <= accept && !s2_reg;
            if (accept) begin
                stable_reg <= s2_reg;
            end
        end
    end

    assign stable_bit = stable_reg;
    assign rise_bit   = rise_reg;
    assign fall_bit   = fall_reg;
    assign accept_bit = accept;

endmodule : debounce_bit

// File: rtl/sw_debounce8.sv
// ---------------------------------------------------------------------------
// sw_debounce8
//   Front end for the switch vector feeding the priority encoder / 7-seg
//   stage. Each bit is synchronised and debounced independently; the top
//   adds registered summary flags.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   raw      in   [WIDTH] asynchronous switch levels
//   stable   out  [WIDTH] debounced levels (encoder x input)
//   rise     out  [WIDTH] per-bit one-cycle pulse on stable 0->1
//   fall     out  [WIDTH] per-bit one-cycle pulse on stable 1->0
//   changed  out  any rise or fall this cycle (registered)
//   any_on   out  |stable, updated on the same edge as stable
//
// DEBOUNCE_CYCLES must be at least 2.
// ---------------------------------------------------------------------------
module sw_debounce8
    import sw_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             any_on
);

    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
    logic [WIDTH-1:0] accept_vec;
    logic [WIDTH-1:0] stable_next;
    logic             changed_reg;
    logic             any_on_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw_bit    (raw[gi]),
                .stable_bit (stable_vec[gi]),
                .rise_bit   (rise_vec[gi]),
                .fall_bit   (fall_vec[gi]),
                .accept_bit (accept_vec[gi])
            );
        end
    endgenerate

    // An accepting lane always flips its stable bit, so the post-edge
    // stable vector is simply the current one XOR the accept mask.
    assign stable_next = stable_vec ^ accept_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_reg <= 1'b0;
            any_on_reg  <= 1'b0;
        end else begin
            changed_reg <= |accept_vec;
            any_on_reg  <= |stable_next;
        end
    end

    assign stable  = stable_vec;
    assign rise    = rise_vec;
    assign fall    = fall_vec;
    assign changed = changed_reg;
    assign any_on  = any_on_reg;

endmodule : sw_debounce8
